// File: rtl/irq_arb_pkg.sv
// irq_arb_pkg: shared FSM states, opcode constants and reset values for the IRQ node arbiter.
package irq_arb_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
    localparam logic [15:0] OP_PRIO_MASK = 16'h3FF0;
    localparam logic [15:0] OP_PRIO_VAL  = 16'h2F10;
    localparam logic [15:0] OP_ACK       = 16'h3F13;
    localparam int          PRIO0_RST    = 2;
    localparam int          PRIO1_RST    = 4;
    localparam logic [1:0]  EXE_BUSY     = 2'b11;
endpackage

// File: rtl/irq_edge_pending.sv
// irq_edge_pending: registers src_req, detects rising edges, latches pending requests and a sticky overflow.
module irq_edge_pending
    import irq_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [NUM_SRC-1:0] clr,
    output logic [NUM_SRC-1:0] pending,
    output logic               overflow
);
    logic [NUM_SRC-1:0] src_req_q, pending_q, pending_d, rise;
    logic               overflow_q, overflow_d;

    // A new edge re-sets a bit even if the grant logic clears it this cycle.
    always_comb begin
        rise       = src_req & ~src_req_q;
        pending_d  = (pending_q & ~clr) | rise;
        overflow_d = overflow_q | (|(rise & pending_q));
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            src_req_q  <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            src_req_q  <= src_req;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending  = pending_q;
    assign overflow = overflow_q;
endmodule

// File: rtl/irq_node_arbiter.sv
// irq_node_arbiter: grants pending interrupt sources to one of two nodes and holds the IRQ for a bounded window.
// Define ROUND_ROBIN_EN for round-robin source selection; default is fixed priority (lowest index).
module irq_node_arbiter
    import irq_arb_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int HOLD_CYCLES = 1001,
    parameter int PRIO_W      = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_SRC-1:0]         src_req,
    input  logic [15:0]                in_op_node0,
    input  logic [15:0]                in_op_node1,
    input  logic [1:0]                 exe_flag_task0,
    input  logic [1:0]                 exe_flag_task1,
    output logic                       irq_node0,
    output logic                       irq_node1,
    output logic [$clog2(NUM_SRC)-1:0] irq_src_id,
    output logic [NUM_SRC-1:0]         pending,
    output logic                       overflow
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(HOLD_CYCLES) + 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               irq0_q, irq0_d, irq1_q, irq1_d;
    logic [SW-1:0]      id_q, id_d, sel;
    logic [PRIO_W-1:0]  prio0_q, prio0_d, prio1_q, prio1_d;
    logic [NUM_SRC-1:0] clr;
    logic               found, busy0, busy1, pick1, ack0, ack1;
`ifdef ROUND_ROBIN_EN
    logic [SW-1:0]      ptr_q, ptr_d, rr_idx;
`endif

    irq_edge_pending #(.NUM_SRC(NUM_SRC)) u_edge (
        .CLK     (CLK),
        .RST     (RST),
        .src_req (src_req),
        .clr     (clr),
        .pending (pending),
        .overflow(overflow)
    );

    always_comb begin
        found = 1'b0;
        sel   = '0;
`ifdef ROUND_ROBIN_EN
        rr_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rr_idx = SW'((int'(ptr_q) + 1 + k) % NUM_SRC);
            if (!found && pending[rr_idx]) begin
                found = 1'b1;
                sel   = rr_idx;
            end
        end
`else
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pending[SW'(i)]) sel = SW'(i);
        found = |pending;
`endif
    end

    // Preferred node is the higher priority (tie to node0); fall back to the other if busy.
    always_comb begin
        busy0   = exe_flag_task0 == EXE_BUSY;
        busy1   = exe_flag_task1 == EXE_BUSY;
        pick1   = (prio1_q > prio0_q) ? !busy1 : busy0;
        ack0    = in_op_node0 == OP_ACK;
        ack1    = in_op_node1 == OP_ACK;
        prio0_d = ((in_op_node0 & OP_PRIO_MASK) == OP_PRIO_VAL) ? PRIO_W'(in_op_node0[3:0]) : prio0_q;
        prio1_d = ((in_op_node1 & OP_PRIO_MASK) == OP_PRIO_VAL) ? PRIO_W'(in_op_node1[3:0]) : prio1_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        irq0_d  = irq0_q;
        irq1_d  = irq1_q;
        id_d    = id_q;
        clr     = '0;
`ifdef ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: if (found && !(busy0 && busy1)) begin
                clr     = NUM_SRC'(1) << sel;
                id_d    = sel;
                irq0_d  = !pick1;
                irq1_d  = pick1;
                cnt_d   = CW'(HOLD_CYCLES - 1);
                state_d = HOLD;
`ifdef ROUND_ROBIN_EN
                ptr_d   = sel;
`endif
            end
            HOLD: if (cnt_q == '0 || (irq0_q && ack0) || (irq1_q && ack1)) begin
                irq0_d  = 1'b0;
                irq1_d  = 1'b0;
                state_d = GAP;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            irq0_q  <= 1'b0;
            irq1_q  <= 1'b0;
            id_q    <= '0;
            prio0_q <= PRIO_W'(PRIO0_RST);
            prio1_q <= PRIO_W'(PRIO1_RST);
`ifdef ROUND_ROBIN_EN
            ptr_q   <= SW'(NUM_SRC - 1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq0_q  <= irq0_d;
            irq1_q  <= irq1_d;
            id_q    <= id_d;
            prio0_q <= prio0_d;
            prio1_q <= prio1_d;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign irq_node0  = irq0_q;
    assign irq_node1  = irq1_q;
    assign irq_src_id = id_q;
endmodule

// File: tb/tb_irq_node_arbiter.sv
// tb_irq_node_arbiter: directed test of grant latency, hold length, node choice, ack, busy, reset and overflow.
module tb_irq_node_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  src_req = '0;
    logic [15:0] in_op_node0 = '0, in_op_node1 = '0;
    logic [1:0]  exe_flag_task0 = '0, exe_flag_task1 = '0;
    logic        irq_node0, irq_node1, overflow;
    logic [1:0]  irq_src_id;
    logic [3:0]  pending;
    int          vectors = 0;
    int          miscompares = 0;

    irq_node_arbiter dut (
        .CLK           (CLK),
        .RST           (RST),
        .src_req       (src_req),
        .in_op_node0   (in_op_node0),
        .in_op_node1   (in_op_node1),
        .exe_flag_task0(exe_flag_task0),
        .exe_flag_task1(exe_flag_task1),
        .irq_node0     (irq_node0),
        .irq_node1     (irq_node1),
        .irq_src_id    (irq_src_id),
        .pending       (pending),
        .overflow      (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("rst_irq0", irq_node0, 0);
        chk("rst_irq1", irq_node1, 0);
        chk("rst_id", irq_src_id, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
        RST = 1'b1;
        tick();
        // 1: default prio 2/4 -> node1, full 1001-cycle hold, then gap
        src_req = 4'b0010;
        tick();
        chk("t1_pending", pending, 4'b0010);
        chk("t1_irq1_early", irq_node1, 0);
        src_req = 4'b0000;
        tick();
        chk("t1_irq1", irq_node1, 1);
        chk("t1_irq0", irq_node0, 0);
        chk("t1_id", irq_src_id, 1);
        chk("t1_pending_clr", pending, 0);
        n = 1;
        while (irq_node1 === 1'b1 && n < 1100) begin
            tick();
            if (irq_node1 === 1'b1) n++;
        end
        chk("t1_hold_len", n, 1001);
        chk("t1_gap_irq0", irq_node0, 0);
        chk("t1_gap_irq1", irq_node1, 0);
        tick();
        tick();
        // 2: prio0 <= 7 beats prio1=4
        in_op_node0 = 16'h2F17;
        tick();
        in_op_node0 = 16'h0000;
        src_req = 4'b0001;
        tick();
        src_req = 4'b0000;
        tick();
        chk("t2_irq0", irq_node0, 1);
        chk("t2_irq1", irq_node1, 0);
        chk("t2_id", irq_src_id, 0);
        in_op_node0 = 16'h3F13;
        tick();
        chk("t2_ack", irq_node0, 0);
        in_op_node0 = 16'h0000;
        tick();
        tick();
        // 3: sources 2 and 3 together -> 2 first, 3 after the gap
        src_req = 4'b1100;
        tick();
        chk("t3_pending", pending, 4'b1100);
        src_req = 4'b0000;
        tick();
        chk("t3_first_irq0", irq_node0, 1);
        chk("t3_first_id", irq_src_id, 2);
        chk("t3_first_pending", pending, 4'b1000);
        in_op_node0 = 16'h3F13;
        tick();
        chk("t3_gap", irq_node0, 0);
        in_op_node0 = 16'h0000;
        tick();
        chk("t3_low2", irq_node0, 0);
        tick();
        chk("t3_second_irq0", irq_node0, 1);
        chk("t3_second_id", irq_src_id, 3);
        chk("t3_second_pending", pending, 0);
        in_op_node0 = 16'h3F13;
        tick();
        in_op_node0 = 16'h0000;
        tick();
        tick();
        // 4: prio1=15 but node1 busy -> node0; both busy -> wait
        in_op_node1 = 16'h2F1F;
        exe_flag_task1 = 2'b11;
        tick();
        in_op_node1 = 16'h0000;
        src_req = 4'b0001;
        tick();
        src_req = 4'b0000;
        tick();
        chk("t4_irq0", irq_node0, 1);
        chk("t4_irq1", irq_node1, 0);
        in_op_node0 = 16'h3F13;
        tick();
        in_op_node0 = 16'h0000;
        exe_flag_task0 = 2'b11;
        tick();
        src_req = 4'b0001;
        tick();
        src_req = 4'b0000;
        tick();
        tick();
        tick();
        chk("t4_busy_pending", pending, 4'b0001);
        chk("t4_busy_irq0", irq_node0, 0);
        chk("t4_busy_irq1", irq_node1, 0);
        exe_flag_task1 = 2'b00;
        tick();
        chk("t4_free_irq1", irq_node1, 1);
        chk("t4_free_id", irq_src_id, 0);
        chk("t4_free_pending", pending, 0);
        // 5: foreign ack ignored, own ack at hold cycle 10 ends the grant
        in_op_node0 = 16'h3F13;
        tick();
        tick();
        tick();
        chk("t5_foreign_ack", irq_node1, 1);
        in_op_node0 = 16'h0000;
        repeat (6) tick();
        chk("t5_cycle10", irq_node1, 1);
        in_op_node1 = 16'h3F13;
        tick();
        chk("t5_ack_irq1", irq_node1, 0);
        chk("t5_ack_irq0", irq_node0, 0);
        in_op_node1 = 16'h0000;
        exe_flag_task0 = 2'b00;
        tick();
        in_op_node1 = 16'h2F10;
        tick();
        in_op_node1 = 16'h0000;
        // 6: reset mid-hold restores prio 2/4; overflow is sticky until reset
        src_req = 4'b0010;
        tick();
        src_req = 4'b0000;
        tick();
        chk("t6_pre_irq0", irq_node0, 1);
        chk("t6_pre_id", irq_src_id, 1);
        repeat (5) tick();
        RST = 1'b0;
        tick();
        chk("t6_rst_irq0", irq_node0, 0);
        chk("t6_rst_irq1", irq_node1, 0);
        chk("t6_rst_id", irq_src_id, 0);
        RST = 1'b1;
        src_req = 4'b0001;
        tick();
        src_req = 4'b0000;
        tick();
        chk("t6_prio_irq1", irq_node1, 1);
        chk("t6_prio_irq0", irq_node0, 0);
        in_op_node1 = 16'h3F13;
        tick();
        in_op_node1 = 16'h0000;
        exe_flag_task0 = 2'b11;
        exe_flag_task1 = 2'b11;
        tick();
        src_req = 4'b0100;
        tick();
        chk("t6_ovf_pending", pending, 4'b0100);
        chk("t6_ovf_clear", overflow, 0);
        src_req = 4'b0000;
        tick();
        src_req = 4'b0100;
        tick();
        chk("t6_ovf_set", overflow, 1);
        src_req = 4'b0000;
        tick();
        tick();
        chk("t6_ovf_sticky", overflow, 1);
        RST = 1'b0;
        tick();
        chk("t6_ovf_rst", overflow, 0);
        chk("t6_pending_rst", pending, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
